// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel renderers.
// The generator drives the counters, syncs, coordinates and strobes. The
// consumer side supplies the pixel enable.
`timescale 1ns/1ps

interface vga_timing_gen_if #(
    parameter int unsigned CW = 10
) ();
    logic          ce;
    logic [CW-1:0] h_counter;
    logic [CW-1:0] v_counter;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  ce,
        output h_counter, v_counter, hsync, vsync, active, x, y, line_start, frame_start
    );

    modport slave (
        output ce,
        input  h_counter, v_counter, hsync, vsync, active, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Each line and each frame run in the
// order sync, back porch, active, front porch. Position 0 is the first sync pixel.
// Decoded outputs are registered from next-state counters, so they line up with
// the counters and do not glitch.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 29,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 10
) (
    input logic              pixel_clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACTIVE;

    // Reject configurations the counters cannot represent, or that make no sense.
    if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (H_SYNC == 0 || H_ACTIVE == 0 || V_SYNC == 0 || V_ACTIVE == 0) begin : g_bad_zero
        $error("vga_timing_gen: sync and active widths must be non-zero");
    end

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic          h_last, v_last, h_act, v_act;
    logic [31:0]   h_ext, v_ext;

    // Next raster position: reset wins, otherwise step once per pixel enable.
    always_comb begin
        h_last = (h_q == CW'(H_TOTAL - 1));
        v_last = (v_q == CW'(V_TOTAL - 1));
        h_d    = h_q;
        v_d    = v_q;
        if (rst) begin
            h_d = '0;
            v_d = '0;
        end else if (bus.ce) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    // Decode syncs and the visible window from the next position. Under reset
    // this yields the (0,0) values: syncs asserted, inactive, zero coordinates.
    always_comb begin
        h_ext    = 32'(h_d);
        v_ext    = 32'(v_d);
        hsync_d  = (h_ext < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = (v_ext < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        h_act    = (h_ext >= H_START) && (h_ext < H_END);
        v_act    = (v_ext >= V_START) && (v_ext < V_END);
        active_d = h_act && v_act;
        x_d      = active_d ? CW'(h_ext - H_START) : '0;
        y_d      = active_d ? CW'(v_ext - V_START) : '0;
    end

    // Position and decoded-output registers.
    always_ff @(posedge pixel_clk) begin
        h_q      <= h_d;
        v_q      <= v_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        active_q <= active_d;
        x_q      <= x_d;
        y_q      <= y_d;
    end

    assign bus.h_counter   = h_q;
    assign bus.v_counter   = v_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.active      = active_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    // Strobes mark the enabled cycle that presents position 0 of a line/frame.
    assign bus.line_start  = bus.ce & ~rst & (h_q == '0);
    assign bus.frame_start = bus.ce & ~rst & (h_q == '0) & (v_q == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: the default 800x521 raster, a narrow-line
// variant with default vertical timing, and a tiny positive-polarity raster.
`timescale 1ns/1ps

module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic d_rst, t_rst, s_rst;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    vga_timing_gen_if #(.CW(10)) d_if ();
    vga_timing_gen_if #(.CW(10)) t_if ();
    vga_timing_gen_if #(.CW(4))  s_if ();

    vga_timing_gen u_dflt (
        .pixel_clk (clk),
        .rst       (d_rst),
        .bus       (d_if)
    );

    // 8-pixel lines (sync 0, active 3..6) with the default 521-line frame.
    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (2)
    ) u_tall (
        .pixel_clk (clk),
        .rst       (t_rst),
        .bus       (t_if)
    );

    // 8x6 raster, active h 3..6 and v 2..4, syncs active-high.
    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (2),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CW (4)
    ) u_small (
        .pixel_clk (clk),
        .rst       (s_rst),
        .bus       (s_if)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each task moves into the next cycle, applies that cycle's inputs and
    // returns with the outputs of that cycle settled.
    task automatic cyc_d(input logic r, input logic c);
        @(posedge clk); #1; d_rst = r; d_if.ce = c; #1;
    endtask
    task automatic cyc_t(input logic r, input logic c);
        @(posedge clk); #1; t_rst = r; t_if.ce = c; #1;
    endtask
    task automatic cyc_s(input logic r, input logic c);
        @(posedge clk); #1; s_rst = r; s_if.ce = c; #1;
    endtask

    int unsigned cnt_a, cnt_b, cnt_c, run, max_run;
    int unsigned prev_h, prev_v;
    logic        prev_ce;

    initial begin
        d_rst = 1'b0; t_rst = 1'b0; s_rst = 1'b0;
        d_if.ce = 1'b0; t_if.ce = 1'b0; s_if.ce = 1'b0;

        // Default raster: reset values, with ce high during reset.
        for (int i = 0; i < 3; i++) cyc_d(1'b1, 1'b1);
        check("rst_h", d_if.h_counter, 0);
        check("rst_v", d_if.v_counter, 0);
        check("rst_hsync", d_if.hsync, 0);
        check("rst_vsync", d_if.vsync, 0);
        check("rst_active", d_if.active, 0);
        check("rst_x", d_if.x, 0);
        check("rst_y", d_if.y, 0);
        check("rst_line_start", d_if.line_start, 0);
        check("rst_frame_start", d_if.frame_start, 0);

        cyc_d(1'b0, 1'b1);
        check("rel_frame_start", d_if.frame_start, 1);
        check("rel_line_start", d_if.line_start, 1);

        // Two full lines: hsync low runs and line_start count.
        cnt_a = 0; cnt_b = 0; run = 0; max_run = 0;
        for (int n = 0; n < 1600; n++) begin
            if (n > 0) cyc_d(1'b0, 1'b1);
            if (d_if.hsync == 1'b0) begin
                cnt_a++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (d_if.line_start) cnt_b++;
        end
        check("hsync_low_cycles", cnt_a, 192);
        check("hsync_low_run", max_run, 96);
        check("line_start_count", cnt_b, 2);
        check("line_end_h", d_if.h_counter, 799);
        check("line_end_v", d_if.v_counter, 1);

        // Active window on line 31.
        repeat (24943 - 1599) cyc_d(1'b0, 1'b1);
        check("pre_act_h", d_if.h_counter, 143);
        check("pre_act_v", d_if.v_counter, 31);
        check("pre_act_active", d_if.active, 0);
        cyc_d(1'b0, 1'b1);
        check("act_first_active", d_if.active, 1);
        check("act_first_x", d_if.x, 0);
        check("act_first_y", d_if.y, 0);
        repeat (639) cyc_d(1'b0, 1'b1);
        check("act_last_h", d_if.h_counter, 783);
        check("act_last_active", d_if.active, 1);
        check("act_last_x", d_if.x, 639);
        cyc_d(1'b0, 1'b1);
        check("post_act_active", d_if.active, 0);
        check("post_act_x", d_if.x, 0);

        // Reset mid-frame, then ce toggling every other cycle.
        cyc_d(1'b1, 1'b1);
        cyc_d(1'b0, 1'b1);
        check("midrst_h", d_if.h_counter, 0);
        check("midrst_v", d_if.v_counter, 0);
        check("midrst_frame_start", d_if.frame_start, 1);
        cnt_a = d_if.line_start ? 1 : 0;
        cnt_b = 0; cnt_c = 0;
        prev_h = d_if.h_counter; prev_v = d_if.v_counter; prev_ce = 1'b1;
        for (int n = 1; n < 1600; n++) begin
            cyc_d(1'b0, (n % 2) == 0);
            if (!prev_ce && (d_if.h_counter != prev_h || d_if.v_counter != prev_v)) cnt_b++;
            if (!d_if.ce && (d_if.line_start || d_if.frame_start)) cnt_c++;
            if (d_if.line_start) cnt_a++;
            prev_h = d_if.h_counter; prev_v = d_if.v_counter; prev_ce = d_if.ce;
        end
        check("ce_line_starts", cnt_a, 1);
        check("ce_hold_violations", cnt_b, 0);
        check("ce_strobe_on_idle", cnt_c, 0);
        check("ce_wrap_h", d_if.h_counter, 0);
        check("ce_wrap_v", d_if.v_counter, 1);
        cyc_d(1'b0, 1'b1);
        check("ce_next_line_start", d_if.line_start, 1);

        // Narrow-line raster: last active lines and frame wrap.
        cyc_t(1'b1, 1'b1);
        cyc_t(1'b0, 1'b1);
        check("t_rel_frame_start", t_if.frame_start, 1);
        repeat (510 * 8 + 3) cyc_t(1'b0, 1'b1);
        check("t_v510_active", t_if.active, 1);
        check("t_v510_x", t_if.x, 0);
        check("t_v510_y", t_if.y, 479);
        repeat (3) cyc_t(1'b0, 1'b1);
        check("t_v510_x_last", t_if.x, 3);
        repeat (5) cyc_t(1'b0, 1'b1);
        check("t_v511_h", t_if.h_counter, 3);
        check("t_v511_active", t_if.active, 0);
        check("t_v511_y", t_if.y, 0);
        repeat (76) cyc_t(1'b0, 1'b1);
        check("t_end_h", t_if.h_counter, 7);
        check("t_end_v", t_if.v_counter, 520);
        check("t_end_vsync", t_if.vsync, 1);
        cyc_t(1'b0, 1'b1);
        check("t_wrap_h", t_if.h_counter, 0);
        check("t_wrap_v", t_if.v_counter, 0);
        check("t_wrap_vsync", t_if.vsync, 0);
        check("t_wrap_frame_start", t_if.frame_start, 1);
        cnt_a = 0;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) cyc_t(1'b0, 1'b1);
            if (t_if.vsync == 1'b0) cnt_a++;
        end
        check("t_vsync_low_cycles", cnt_a, 16);

        // Tiny positive-polarity raster: one full frame, then reset at (5,2).
        cyc_s(1'b1, 1'b1);
        cyc_s(1'b0, 1'b1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int n = 0; n < 48; n++) begin
            if (n > 0) cyc_s(1'b0, 1'b1);
            if (s_if.hsync) begin
                cnt_a++;
                if (s_if.h_counter != 0) cnt_c++;
            end
            if (s_if.active) begin
                cnt_b++;
                if (s_if.h_counter < 3 || s_if.h_counter > 6 ||
                    s_if.v_counter < 2 || s_if.v_counter > 4 ||
                    32'(s_if.x) != 32'(s_if.h_counter) - 3 ||
                    32'(s_if.y) != 32'(s_if.v_counter) - 2) cnt_c++;
            end
        end
        check("s_hsync_high_cycles", cnt_a, 6);
        check("s_active_cycles", cnt_b, 12);
        check("s_decode_violations", cnt_c, 0);
        repeat (22) cyc_s(1'b0, 1'b1);
        check("s_pre_rst_h", s_if.h_counter, 5);
        check("s_pre_rst_v", s_if.v_counter, 2);
        check("s_pre_rst_x", s_if.x, 2);
        check("s_pre_rst_y", s_if.y, 0);
        s_rst = 1'b1;
        #1;
        check("s_rst_line_start", s_if.line_start, 0);
        cyc_s(1'b0, 1'b1);
        check("s_post_rst_h", s_if.h_counter, 0);
        check("s_post_rst_v", s_if.v_counter, 0);
        check("s_post_rst_hsync", s_if.hsync, 1);
        check("s_post_rst_vsync", s_if.vsync, 1);
        check("s_post_rst_active", s_if.active, 0);
        check("s_post_rst_frame_start", s_if.frame_start, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: next generation of the fixed 640x480 sync counter. Produces horizontal/vertical counters, sync pulses of configurable polarity, an active-video flag, active-area pixel coordinates and line/frame start strobes. All timing is set by porch/sync/active parameters, and counting is gated by a pixel clock enable. It sits between the pixel clock domain and the pixel renderers (snake board, score overlay), which consume `x`, `y` and `active`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync`
- `CW`, 10, width of all counter/coordinate outputs
- `pixel_clk` input 1: sole clock, all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `ce` input 1: pixel enable; counters advance only on cycles with `ce`=1
- `h_counter` output CW: horizontal position within the line, 0..H_TOTAL-1
- `v_counter` output CW: vertical line within the frame, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync, level per HSYNC_POL
- `vsync` output 1: vertical sync, level per VSYNC_POL
- `active` output 1: current position inside visible area
- `x` output CW: active-area column, 0..H_ACTIVE-1; 0 when not active
- `y` output CW: active-area row, 0..V_ACTIVE-1; 0 when not active
- `line_start` output 1: one-cycle strobe at start of each line
- `frame_start` output 1: one-cycle strobe at start of each frame

## Operation
- Derived: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP, V_TOTAL similarly. H_START = H_SYNC+H_BP, H_END = H_START+H_ACTIVE. V_START and V_END are defined the same way. Defaults give 800x521, active h 144..783, v 31..510.
- Line order: sync, back porch, active, front porch. Position 0 is the first sync pixel/line.
- Elaboration error if H_TOTAL or V_TOTAL > 2^CW, or if any of H_SYNC, H_ACTIVE, V_SYNC, V_ACTIVE is 0.
- Counting, on a `ce`=1 cycle:
  - if h_counter < H_TOTAL-1, h_counter increments;
  - otherwise h_counter wraps to 0, and v_counter increments, or wraps to 0 when at V_TOTAL-1.
- `ce`=0: all registered state holds.
- `hsync` = HSYNC_POL when h_counter < H_SYNC, else ~HSYNC_POL. `vsync` = VSYNC_POL when v_counter < V_SYNC, else ~VSYNC_POL. Sync levels depend only on the counters; `ce` does not gate them.
- `active` = (H_START <= h_counter < H_END) and (V_START <= v_counter < V_END).
- When active: `x` = h_counter-H_START and `y` = v_counter-V_START, truncated to CW. Otherwise `x` = `y` = 0.
- `hsync`, `vsync`, `active`, `x` and `y` are registers. They are decoded from next-state counter values so that they always describe the h_counter/v_counter values presented in the same cycle, and they never glitch.
- `line_start` = ce & (h_counter==0). `frame_start` = ce & (h_counter==0) & (v_counter==0). Both are forced 0 while `rst`=1.

## Timing
- Reset (`rst`=1 at an edge): h_counter=0, v_counter=0, hsync=HSYNC_POL, vsync=VSYNC_POL, active=0, x=0, y=0. `rst` overrides `ce`.
- First cycle after reset release: the outputs describe position (0,0). If `ce`=1 in that cycle, `frame_start` and `line_start` are 1.
- Reset asserted mid-frame: the next cycle shows (0,0) state regardless of prior position. No partial line is completed.
- Latency from counter change to decoded outputs: 0 cycles (aligned).
- With `ce` held high, one line takes H_TOTAL clocks and one frame takes H_TOTAL*V_TOTAL clocks (416,800 clocks with defaults).
- The `ce` duty cycle is arbitrary. Outputs step once per `ce` pulse.
- The frame wrap (h=H_TOTAL-1, v=V_TOTAL-1, ce=1) goes to (0,0) in one step, with both strobes high in the following `ce` cycle.

## Test plan
- Reset values: hold `rst` for 3 cycles with ce=1 -> h=v=0, hsync=vsync=0, active=x=y=0, strobes 0. After release, frame_start=1 in the first cycle.
- Line timing, defaults, ce=1: hsync low for exactly 96 consecutive cycles out of every 800, and line_start high once per 800 cycles.
- Active window on line v=31: active rises at h=144 with x=0, y=0 and falls after h=783 with x=639. At v=510, y=479. At v=511, active=0.
- Frame wrap: drive to h=799, v=520 with ce=1 -> next cycle h=0, v=0, vsync=0, frame_start=1. vsync stays low for exactly 2 lines (1600 cycles).
- ce gating: toggle ce every other cycle -> a line takes 1600 clocks, values hold on ce=0 cycles, and strobes are never asserted on ce=0 cycles.
- Small config (H 4/1/2/1, V 3/1/1/1, both POLs=1, CW=4) with reset pulsed at h=5,v=2: hsync is high only at h=0, active for h 3..6 and v 2..4, and the cycle after reset shows (0,0).
